// File: rtl/ysyx_22050598_exu_trap_redir.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_exu_trap_redir
//
// Sits behind the EXU CSR unit and turns its csr_rd_pc_data result into
// either a GPR writeback (Zicsr ops) or a held PC redirect to the IFU
// (ecall -> mtvec, mret -> mepc). While a redirect is outstanding, and for a
// fixed drain window after the IFU takes it, younger stages are flushed and
// EXU issue is stalled.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   ex_valid_i/ready_o  EXU issue handshake (ready only in IDLE)
//   ex_csr_ena_i        instruction is a Zicsr op
//   ex_is_ecall_i       instruction is ecall
//   ex_is_mret_i        instruction is mret
//   ex_rd_idx_i         GPR destination of the CSR op
//   csr_rd_pc_data_i    CSR read value / mtvec / mepc from the CSR unit
//   wb_valid_o/idx/data one-cycle GPR write strobe, index and data
//   redir_valid_o/pc_o  redirect request to IFU, held until redir_ready_i
//   redir_ready_i       IFU accepts the redirect
//   flush_o             kill everything younger than the trapping op
//   trap_cnt_o          number of completed redirects (wraps)
// ---------------------------------------------------------------------------
module ysyx_22050598_exu_trap_redir #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,   // 1..15
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic             ex_csr_ena_i,
  input  logic             ex_is_ecall_i,
  input  logic             ex_is_mret_i,
  input  logic [4:0]       ex_rd_idx_i,
  input  logic [XLEN-1:0]  csr_rd_pc_data_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_idx_o,
  output logic [XLEN-1:0]  wb_rd_data_o,
  output logic             redir_valid_o,
  input  logic             redir_ready_i,
  output logic [XLEN-1:0]  redir_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] trap_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Drain counter is loaded with FLUSH_CYCLES-1 and counts down to 0, so
  // DRAIN lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_drain_cnt;
  logic [3:0]        w_drain_cnt_nxt;

  logic              r_wb_valid;
  logic [4:0]        r_wb_rd_idx;
  logic [XLEN-1:0]   r_wb_rd_data;
  logic [XLEN-1:0]   r_redir_pc;
  logic [CNT_W-1:0]  r_trap_cnt;

  logic              w_idle;
  logic              w_accept;
  logic              w_is_trap;
  logic              w_csr_wr;
  logic              w_trap_take;
  logic              w_redir_fire;

  // ---------------------------------------------------------------------
  // Issue-side decode. Only meaningful in IDLE; ops presented while busy
  // are simply not accepted and the EXU keeps holding them.
  // ---------------------------------------------------------------------
  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = ex_valid_i & w_idle;
  // ecall and mret share one redirect path: the CSR unit already put the
  // right target (mtvec or mepc) on csr_rd_pc_data_i, so both-high simply
  // yields one redirect. A trap op also masks any csr_ena on the same op.
  assign w_is_trap   = ex_is_ecall_i | ex_is_mret_i;
  assign w_trap_take = w_accept & w_is_trap;
  // x0 writes are dropped here rather than relying on the regfile.
  assign w_csr_wr    = w_accept & ex_csr_ena_i & ~w_is_trap
                     & (ex_rd_idx_i != 5'd0);
  assign w_redir_fire = (r_state == S_REDIR) & redir_ready_i;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_trap_take) w_state_nxt = S_REDIR;
      end
      S_REDIR: begin
        if (redir_ready_i) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 4'd0) w_state_nxt = S_IDLE;
        else                     w_drain_cnt_nxt = r_drain_cnt - 4'd1;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_drain_cnt_nxt = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= 4'd0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_idx  <= 5'd0;
      r_wb_rd_data <= '0;
      r_redir_pc   <= '0;
      r_trap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;

      // Strobe lasts one cycle; idx/data keep their last written value.
      r_wb_valid <= w_csr_wr;
      if (w_csr_wr) begin
        r_wb_rd_idx  <= ex_rd_idx_i;
        r_wb_rd_data <= csr_rd_pc_data_i;
      end

      // Target captured once on accept and held for the whole REDIR phase.
      if (w_trap_take)
        r_redir_pc <= {csr_rd_pc_data_i[XLEN-1:2], 2'b00};

      if (w_redir_fire)
        r_trap_cnt <= r_trap_cnt + CNT_W'(1);
    end
  end

  // All outputs come straight from registers: no ex_* -> redir/wb path.
  assign ex_ready_o    = w_idle;
  assign redir_valid_o = (r_state == S_REDIR);
  assign flush_o       = (r_state != S_IDLE);
  assign redir_pc_o    = r_redir_pc;
  assign wb_valid_o    = r_wb_valid;
  assign wb_rd_idx_o   = r_wb_rd_idx;
  assign wb_rd_data_o  = r_wb_rd_data;
  assign trap_cnt_o    = r_trap_cnt;

endmodule

// File: tb/tb_ysyx_22050598_exu_trap_redir.sv
module tb_ysyx_22050598_exu_trap_redir;
  localparam int XLEN = 64;
  localparam int F    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ex_valid_i, ex_csr_ena_i, ex_is_ecall_i, ex_is_mret_i;
  logic [4:0]      ex_rd_idx_i;
  logic [XLEN-1:0] csr_rd_pc_data_i;
  logic            redir_ready_i;

  logic            ex_ready_o, wb_valid_o, redir_valid_o, flush_o;
  logic [4:0]      wb_rd_idx_o;
  logic [XLEN-1:0] wb_rd_data_o, redir_pc_o;
  logic [31:0]     trap_cnt_o;

  // narrow-counter copy: shares all inputs, used to exercise counter wrap
  logic            s_ex_ready, s_wb_valid, s_redir_valid, s_flush;
  logic [4:0]      s_wb_idx;
  logic [XLEN-1:0] s_wb_data, s_redir_pc;
  logic [1:0]      s_trap_cnt;

  ysyx_22050598_exu_trap_redir #(.XLEN(XLEN), .FLUSH_CYCLES(F), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_csr_ena_i(ex_csr_ena_i), .ex_is_ecall_i(ex_is_ecall_i), .ex_is_mret_i(ex_is_mret_i),
    .ex_rd_idx_i(ex_rd_idx_i), .csr_rd_pc_data_i(csr_rd_pc_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_data_o(wb_rd_data_o),
    .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i), .redir_pc_o(redir_pc_o),
    .flush_o(flush_o), .trap_cnt_o(trap_cnt_o));

  ysyx_22050598_exu_trap_redir #(.XLEN(XLEN), .FLUSH_CYCLES(F), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(s_ex_ready),
    .ex_csr_ena_i(ex_csr_ena_i), .ex_is_ecall_i(ex_is_ecall_i), .ex_is_mret_i(ex_is_mret_i),
    .ex_rd_idx_i(ex_rd_idx_i), .csr_rd_pc_data_i(csr_rd_pc_data_i),
    .wb_valid_o(s_wb_valid), .wb_rd_idx_o(s_wb_idx), .wb_rd_data_o(s_wb_data),
    .redir_valid_o(s_redir_valid), .redir_ready_i(redir_ready_i), .redir_pc_o(s_redir_pc),
    .flush_o(s_flush), .trap_cnt_o(s_trap_cnt));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_cnt = 0;   // completed redirects since last reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic csr, input logic ec, input logic mr,
                       input logic [4:0] rd, input logic [63:0] d);
    ex_valid_i = v; ex_csr_ena_i = csr; ex_is_ecall_i = ec; ex_is_mret_i = mr;
    ex_rd_idx_i = rd; csr_rd_pc_data_i = d;
  endtask

  // mret whose redirect is accepted in the first REDIR cycle
  task automatic mret_quick(input logic [63:0] d);
    drive(1, 0, 0, 1, 0, d);
    redir_ready_i = 1'b1;            // ignored while IDLE
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("mret_redir_valid", redir_valid_o, i == 1);
      if (i == 1) chk("mret_pc", redir_pc_o, d & ~64'h3);
      chk("mret_flush", flush_o, i <= 3);
      chk("mret_ex_ready", ex_ready_o, i == 4);
      chk("mret_wb_valid", wb_valid_o, 0);
      chk("mret_cnt", trap_cnt_o, (i == 1) ? exp_cnt : exp_cnt + 1);
      redir_ready_i = (i == 1);
      step();
    end
    exp_cnt++;
    redir_ready_i = 1'b0;
  endtask

  // ---------------- reference model for the random phase -------------------
  // Busy status is kept as "redirect outstanding" plus "flush cycles left".
  bit          m_redir;
  int          m_drain_left;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_wb_v;
  logic [4:0]  m_wb_idx;
  logic [63:0] m_wb_data;

  task automatic model_reset();
    m_redir = 0; m_drain_left = 0; m_pc = 0; m_cnt = 0;
    m_wb_v = 0; m_wb_idx = 0; m_wb_data = 0;
  endtask

  task automatic model_edge();
    bit idle, acc, trap;
    if (rst) begin
      model_reset();
      return;
    end
    idle = !m_redir && (m_drain_left == 0);
    acc  = ex_valid_i && idle;
    trap = ex_is_ecall_i || ex_is_mret_i;
    m_wb_v = acc && ex_csr_ena_i && !trap && (ex_rd_idx_i != 0);
    if (m_wb_v) begin
      m_wb_idx = ex_rd_idx_i; m_wb_data = csr_rd_pc_data_i;
    end
    if (m_redir && redir_ready_i) begin
      m_redir = 0; m_drain_left = F; m_cnt = m_cnt + 1;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end
    if (acc && trap) begin
      m_redir = 1;
      m_pc = csr_rd_pc_data_i - (csr_rd_pc_data_i % 4);
    end
  endtask

  task automatic model_check();
    bit busy;
    busy = m_redir || (m_drain_left > 0);
    chk("rnd_ex_ready", ex_ready_o, !busy);
    chk("rnd_flush", flush_o, busy);
    chk("rnd_redir_valid", redir_valid_o, m_redir);
    if (m_redir) chk("rnd_redir_pc", redir_pc_o, m_pc);
    chk("rnd_wb_valid", wb_valid_o, m_wb_v);
    if (m_wb_v) begin
      chk("rnd_wb_idx", wb_rd_idx_o, m_wb_idx);
      chk("rnd_wb_data", wb_rd_data_o, m_wb_data);
    end
    chk("rnd_cnt", trap_cnt_o, m_cnt);
    chk("rnd_s_cnt", s_trap_cnt, m_cnt % 4);
    chk("rnd_s_flush", s_flush, busy);
    chk("rnd_s_ex_ready", s_ex_ready, !busy);
    chk("rnd_s_redir_valid", s_redir_valid, m_redir);
    if (m_redir) chk("rnd_s_redir_pc", s_redir_pc, m_pc);
    chk("rnd_s_wb_valid", s_wb_valid, m_wb_v);
    if (m_wb_v) begin
      chk("rnd_s_wb_idx", s_wb_idx, m_wb_idx);
      chk("rnd_s_wb_data", s_wb_data, m_wb_data);
    end
  endtask

  typedef struct {
    logic v, csr, ec, mr;
    logic [4:0]  rd;
    logic [63:0] d;
    logic        ev;
    logic [4:0]  eidx;
    logic [63:0] ed;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  64'h1800,              1'b1, 5'd5,  64'h1800};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  64'hDEAD,              1'b0, 5'd0,  64'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  64'h55,                1'b0, 5'd0,  64'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd4,  64'h77,                1'b0, 5'd0,  64'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd1,  64'h3,                 1'b1, 5'd1,  64'h3};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd6,  64'hA5A5_5A5A_0123_4567, 1'b1, 5'd6,  64'hA5A5_5A5A_0123_4567};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  64'h9,                 1'b0, 5'd0,  64'h0};

    // ---- power-on reset ----
    rst = 1'b1; redir_ready_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("rst_ex_ready", ex_ready_o, 1);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_idx", wb_rd_idx_o, 0);
    chk("rst_wb_data", wb_rd_data_o, 0);
    chk("rst_redir_valid", redir_valid_o, 0);
    chk("rst_redir_pc", redir_pc_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_cnt", trap_cnt_o, 0);
    rst = 1'b0;

    // ---- back-to-back CSR ops from the table ----
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].csr, tbl[i].ec, tbl[i].mr, tbl[i].rd, tbl[i].d);
      step();
      chk("tbl_wb_valid", wb_valid_o, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_wb_idx", wb_rd_idx_o, tbl[i].eidx);
        chk("tbl_wb_data", wb_rd_data_o, tbl[i].ed);
      end
      chk("tbl_ex_ready", ex_ready_o, 1);
      chk("tbl_redir_valid", redir_valid_o, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    // ---- ecall, IFU stalls 3 cycles ----
    drive(1, 0, 1, 0, 0, 64'h8000_0103);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      chk("ecall_redir_valid", redir_valid_o, i <= 4);
      if (i <= 4) chk("ecall_pc", redir_pc_o, 64'h8000_0100);
      chk("ecall_flush", flush_o, i <= 6);
      chk("ecall_ex_ready", ex_ready_o, i == 7);
      chk("ecall_wb_valid", wb_valid_o, 0);
      chk("ecall_cnt", trap_cnt_o, (i <= 4) ? exp_cnt : exp_cnt + 1);
      redir_ready_i = (i == 4);
      step();
    end
    exp_cnt++;
    redir_ready_i = 1'b0;

    // ---- mret, immediate ready ----
    mret_quick(64'h8000_0040);

    // ---- ecall+mret+csr together, then a CSR op held during the trap ----
    drive(1, 1, 1, 1, 5'd9, 64'h8000_0206);
    step();
    drive(1, 1, 0, 0, 5'd7, 64'h1234);
    for (int i = 1; i <= 7; i++) begin
      chk("combo_redir_valid", redir_valid_o, i <= 2);
      if (i <= 2) chk("combo_pc", redir_pc_o, 64'h8000_0204);
      chk("combo_flush", flush_o, i <= 4);
      chk("combo_ex_ready", ex_ready_o, i >= 5);
      chk("combo_wb_valid", wb_valid_o, i == 6);
      if (i == 6) begin
        chk("combo_wb_idx", wb_rd_idx_o, 7);
        chk("combo_wb_data", wb_rd_data_o, 64'h1234);
        drive(0, 0, 0, 0, 0, 0);
      end
      chk("combo_cnt", trap_cnt_o, (i <= 2) ? exp_cnt : exp_cnt + 1);
      redir_ready_i = (i == 2);
      step();
    end
    exp_cnt++;
    redir_ready_i = 1'b0;

    // ---- counter wrap: narrow copy sits at all-ones, one more redirect ----
    chk("wrap_pre_s_cnt", s_trap_cnt, 2'b11);
    mret_quick(64'h0000_1000);
    chk("wrap_s_cnt", s_trap_cnt, 0);
    chk("wrap_cnt", trap_cnt_o, exp_cnt);

    // ---- reset mid-REDIR ----
    drive(1, 0, 1, 0, 0, 64'h8000_0000);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("midrst_in_redir", redir_valid_o, 1);
    rst = 1'b1;
    repeat (3) step();
    chk("midrst_ex_ready", ex_ready_o, 1);
    chk("midrst_redir_valid", redir_valid_o, 0);
    chk("midrst_redir_pc", redir_pc_o, 0);
    chk("midrst_flush", flush_o, 0);
    chk("midrst_wb_valid", wb_valid_o, 0);
    chk("midrst_wb_data", wb_rd_data_o, 0);
    chk("midrst_cnt", trap_cnt_o, 0);
    chk("midrst_s_cnt", s_trap_cnt, 0);
    rst = 1'b0;
    redir_ready_i = 1'b1;
    step();
    chk("postrst_redir_valid", redir_valid_o, 0);
    chk("postrst_flush", flush_o, 0);
    chk("postrst_cnt", trap_cnt_o, 0);
    exp_cnt = 0;

    // ---- randomized traffic against the model ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 500; c++) begin
      int k;
      logic [4:0] rd;
      logic [63:0] d;
      k  = $urandom_range(0, 9);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d  = {$urandom, $urandom};
      case (k)
        0, 1, 2, 3: drive(1, 1, 0, 0, rd, d);
        4: drive(0, 1, 0, 0, rd, d);
        5: drive(1, 0, 1, 0, rd, d);
        6: drive(1, 0, 0, 1, rd, d);
        7: drive(1, 1, 1, 1, rd, d);
        8: drive(1, 0, 0, 0, rd, d);
        default: drive(1, 1, 1, 0, rd, d);
      endcase
      redir_ready_i = ($urandom_range(0, 9) < 4);
      rst = ($urandom_range(0, 99) == 0);
      model_edge();
      step();
      model_check();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
